// File: rtl/pwm_breath_ctrl.sv
// Breathing PWM sequencer: ramps duty up, holds high, ramps down, holds low; duty only moves on period boundaries.
// pwm_out is registered (one clock behind period_cnt); start is ignored while busy, stop lands at the next period end.
module pwm_breath_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int PWM_HZ       = 1000,
  parameter int STEPS        = 100,
  parameter int HOLD_PERIODS = 50,
  parameter int CYCLES       = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       stop,
  output logic       pwm_out,
  output logic       busy,
  output logic [7:0] duty_level,
  output logic       cycle_done
);

  localparam int PERIOD_MAX = CLK_HZ / PWM_HZ;
  localparam int STEP_CNT   = PERIOD_MAX / STEPS;
  localparam int HOLD_W     = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam int CYC_W      = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  localparam logic [25:0]       PER_LAST  = 26'(PERIOD_MAX - 1);
  localparam logic [25:0]       STEP_INC  = 26'(STEP_CNT);
  localparam logic [7:0]        DUTY_MAX  = 8'(STEPS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);

  if (PERIOD_MAX % STEPS != 0) begin : g_chk_steps
    $fatal(1, "PERIOD_MAX must be an exact multiple of STEPS");
  end
  if (HOLD_PERIODS < 1) begin : g_chk_hold
    $fatal(1, "HOLD_PERIODS must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } state_t;

  state_t             state, state_nx;
  logic [25:0]        period_cnt;
  logic [25:0]        threshold, thr_nx;
  logic [7:0]         duty_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;
  logic [CYC_W-1:0]   cyc_cnt, cyc_nx;
  logic               stop_pending, stop_nx;
  logic               done_nx;
  logic               period_end;

  assign busy       = (state != IDLE);
  assign period_end = busy && (period_cnt == PER_LAST);

  always_comb begin
    state_nx = state;
    duty_nx  = duty_level;
    thr_nx   = threshold;
    hold_nx  = hold_cnt;
    cyc_nx   = cyc_cnt;
    stop_nx  = stop_pending;
    done_nx  = 1'b0;

    if (state == IDLE) begin
      if (start && !stop) begin
        state_nx = RAMP_UP;
        duty_nx  = 8'd0;
        thr_nx   = 26'd0;
        hold_nx  = '0;
        cyc_nx   = '0;
      end
    end else begin
      stop_nx = stop_pending | stop;
      if (period_end) begin
        // A pending (or same-cycle) stop wins over every profile transition
        if (stop_pending || stop) begin
          state_nx = IDLE;
          duty_nx  = 8'd0;
          thr_nx   = 26'd0;
          hold_nx  = '0;
          cyc_nx   = '0;
          stop_nx  = 1'b0;
        end else begin
          case (state)
            RAMP_UP: begin
              duty_nx = duty_level + 8'd1;
              thr_nx  = threshold + STEP_INC;
              if (duty_level == DUTY_MAX - 8'd1) begin
                state_nx = HOLD_HIGH;
                hold_nx  = '0;
              end
            end
            HOLD_HIGH: begin
              hold_nx = hold_cnt + HOLD_ONE;
              if (hold_cnt == HOLD_LAST) begin
                state_nx = RAMP_DOWN;
                duty_nx  = DUTY_MAX - 8'd1;
                thr_nx   = threshold - STEP_INC;
                hold_nx  = '0;
              end
            end
            RAMP_DOWN: begin
              duty_nx = duty_level - 8'd1;
              thr_nx  = threshold - STEP_INC;
              if (duty_level == 8'd1) begin
                state_nx = HOLD_LOW;
                hold_nx  = '0;
              end
            end
            HOLD_LOW: begin
              hold_nx = hold_cnt + HOLD_ONE;
              if (hold_cnt == HOLD_LAST) begin
                done_nx = 1'b1;
                hold_nx = '0;
                duty_nx = 8'd0;
                if (CYCLES != 0 && cyc_cnt == CYC_LAST) begin
                  state_nx = IDLE;
                  cyc_nx   = '0;
                end else begin
                  state_nx = RAMP_UP;
                  cyc_nx   = cyc_cnt + CYC_ONE;
                end
              end
            end
            default: state_nx = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      period_cnt   <= 26'd0;
      threshold    <= 26'd0;
      duty_level   <= 8'd0;
      hold_cnt     <= '0;
      cyc_cnt      <= '0;
      stop_pending <= 1'b0;
      cycle_done   <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      state        <= state_nx;
      threshold    <= thr_nx;
      duty_level   <= duty_nx;
      hold_cnt     <= hold_nx;
      cyc_cnt      <= cyc_nx;
      stop_pending <= stop_nx;
      cycle_done   <= done_nx;
      period_cnt   <= (state == IDLE || period_end) ? 26'd0 : period_cnt + 26'd1;
      pwm_out      <= busy && (period_cnt < threshold);
    end
  end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Bench for pwm_breath_ctrl: one auto-stopping instance (CYCLES=1) and one free-running instance (CYCLES=0).
module tb_pwm_breath_ctrl;

  localparam int PER   = 10;
  localparam int STEPS = 5;
  localparam int SCNT  = PER / STEPS;
  localparam int HOLD  = 2;
  localparam int NPER  = STEPS + HOLD + (STEPS - 1) + HOLD;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start_a = 1'b0, stop_a = 1'b0;
  logic       start_b = 1'b0, stop_b = 1'b0;
  logic       pwm_a, busy_a, done_a;
  logic       pwm_b, busy_b, done_b;
  logic [7:0] duty_a, duty_b;

  int vec  = 0;
  int miss = 0;
  int prof[$];

  always #5 sys_clk = ~sys_clk;

  pwm_breath_ctrl #(.CLK_HZ(1000), .PWM_HZ(100), .STEPS(STEPS), .HOLD_PERIODS(HOLD), .CYCLES(1)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_a), .stop(stop_a),
    .pwm_out(pwm_a), .busy(busy_a), .duty_level(duty_a), .cycle_done(done_a)
  );

  pwm_breath_ctrl #(.CLK_HZ(1000), .PWM_HZ(100), .STEPS(STEPS), .HOLD_PERIODS(HOLD), .CYCLES(0)) u_dut_free (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_b), .stop(stop_b),
    .pwm_out(pwm_b), .busy(busy_b), .duty_level(duty_b), .cycle_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One full breath on the CYCLES=1 instance; poke >= 0 pulses start while busy at that clock.
  task automatic run_breath(input string tag, input int poke);
    int hi[NPER];
    int dones;
    int busy_lost;
    foreach (hi[i]) hi[i] = 0;
    dones = 0;
    busy_lost = 0;
    repeat ($urandom_range(1, 5)) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({tag, "_busy_after_start"}, busy_a, 1);
    chk({tag, "_duty_after_start"}, duty_a, 0);
    for (int k = 1; k <= NPER * PER; k++) begin
      tick();
      hi[(k - 1) / PER] += pwm_a;
      dones += done_a;
      if (k < NPER * PER && !busy_a) busy_lost++;
      if (k % PER == 0 && k < NPER * PER)
        chk($sformatf("%s_duty_p%0d", tag, k / PER), duty_a, prof[k / PER]);
      start_a = (k == poke);
    end
    chk({tag, "_cycle_done_at_end"}, done_a, 1);
    chk({tag, "_busy_at_end"}, busy_a, 0);
    chk({tag, "_duty_at_end"}, duty_a, 0);
    chk({tag, "_cycle_done_count"}, dones, 1);
    chk({tag, "_busy_dropouts"}, busy_lost, 0);
    foreach (hi[p]) chk($sformatf("%s_high_p%0d", tag, p), hi[p], prof[p] * SCNT);
    tick();
    chk({tag, "_cycle_done_one_shot"}, done_a, 0);
    chk({tag, "_idle_pwm"}, pwm_a, 0);
  endtask

  initial begin
    int hi_b[4];
    int ks, r, dones;

    for (int d = 0; d < STEPS; d++) prof.push_back(d);
    repeat (HOLD) prof.push_back(STEPS);
    for (int d = STEPS - 1; d >= 1; d--) prof.push_back(d);
    repeat (HOLD) prof.push_back(0);

    #23;
    chk("rst_pwm", pwm_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_duty", duty_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy_free", busy_b, 0);
    tick();
    sys_rst = 1'b0;
    tick();

    // Plain breath, then one with a random start pulse during the ramp down
    run_breath("run", -1);
    run_breath("poke", STEPS * PER + HOLD * PER + $urandom_range(0, (STEPS - 1) * PER - 1));

    // Stop mid-period at duty 3 on the free-running instance
    foreach (hi_b[i]) hi_b[i] = 0;
    dones = 0;
    ks = 3 * PER + $urandom_range(0, PER - 1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 4 * PER; k++) begin
      tick();
      hi_b[(k - 1) / PER] += pwm_b;
      dones += done_b;
      if (k == 3 * PER) chk("stop_duty_before", duty_b, 3);
      if (k == 4 * PER - 1) chk("stop_busy_until_end", busy_b, 1);
      stop_b = (k == ks);
    end
    chk("stop_busy_after", busy_b, 0);
    chk("stop_duty_after", duty_b, 0);
    foreach (hi_b[p]) chk($sformatf("stop_high_p%0d", p), hi_b[p], prof[p] * SCNT);
    tick();
    dones += done_b;
    chk("stop_pwm_idle", pwm_b, 0);
    chk("stop_no_cycle_done", dones, 0);

    // start and stop together while idle
    start_a = 1'b1;
    stop_a  = 1'b1;
    tick();
    start_a = 1'b0;
    stop_a  = 1'b0;
    chk("both_busy", busy_a, 0);
    chk("both_pwm", pwm_a, 0);
    repeat (PER + 2) tick();
    chk("both_busy_later", busy_a, 0);
    chk("both_pwm_later", pwm_a, 0);

    // Asynchronous reset while holding high
    r = $urandom_range(2, PER - 2);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (STEPS * PER + r) tick();
    chk("hold_pwm_high", pwm_a, 1);
    chk("hold_busy", busy_a, 1);
    chk("hold_duty", duty_a, STEPS);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("arst_pwm", pwm_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_duty", duty_a, 0);
    chk("arst_done", done_a, 0);
    #2;
    sys_rst = 1'b0;
    tick();
    chk("post_arst_busy", busy_a, 0);
    chk("post_arst_pwm", pwm_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
